// File: rtl/dm_responder.sv
// Processor data-memory responder: bulk load, single-cycle processor access, optional dump.
// Define DM_DUMP_EN to include the DUMP state; otherwise RUN ends directly in DONE.
module dm_responder #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       ar_in,
  input  logic [16:0]       bus_in,
  input  logic              dm_en,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic              proc_go,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {LOAD, RUN, DUMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] dm_out_q, dm_out_d;
  logic              proc_go_q, proc_go_d;
  logic              ld_ready_q, ld_ready_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ld_fire, run_wr, mem_we;
  logic [AW-1:0]     ar_addr, mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              sig_unused;

  // Upper address/bus bits are deliberately discarded (address wrap by truncation).
  assign sig_unused = ^{ar_in, bus_in, out_ready};
  assign ar_addr    = ar_in[AW-1:0];

  always_comb begin
    ld_fire   = (state_q == LOAD) && ld_ready_q && ld_valid;
    run_wr    = (state_q == RUN) && dm_en;
    mem_we    = ld_fire || run_wr;
    mem_waddr = ld_fire ? ld_addr_q : ar_addr;
    mem_wdata = ld_fire ? ld_data : bus_in[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

`ifdef DM_DUMP_EN
  logic [AW-1:0]     dump_addr_q, dump_addr_d, dump_nxt;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_comb begin
    dump_addr_d = dump_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dump_nxt    = dump_addr_q + AW'(1);
    if (state_q == RUN && end_process) begin
      // A write to word 0 on the exit edge must show up in the first dump beat.
      out_valid_d = 1'b1;
      dump_addr_d = '0;
      out_data_d  = (run_wr && ar_addr == '0) ? mem_wdata : mem_q[0];
    end else if (state_q == DUMP && out_valid_q && out_ready) begin
      if (dump_addr_q == LAST_ADDR) begin
        out_valid_d = 1'b0;
      end else begin
        dump_addr_d = dump_nxt;
        out_data_d  = mem_q[dump_nxt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      dump_addr_q <= dump_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`else
  assign out_valid = 1'b0;
  assign out_data  = '0;
`endif

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    dm_out_d  = dm_out_q;
    unique case (state_q)
      LOAD: begin
        if (ld_fire) begin
          if (ld_last || ld_addr_q == LAST_ADDR) begin
            state_d   = RUN;
            ld_addr_d = '0;
          end else begin
            ld_addr_d = ld_addr_q + AW'(1);
          end
        end
      end
      RUN: begin
        dm_out_d = run_wr ? mem_wdata : mem_q[ar_addr];
        if (end_process) begin
`ifdef DM_DUMP_EN
          state_d = DUMP;
`else
          state_d = DONE;
`endif
        end
      end
      DUMP: begin
`ifdef DM_DUMP_EN
        if (out_valid_q && out_ready && dump_addr_q == LAST_ADDR) state_d = DONE;
`else
        state_d = DONE;
`endif
      end
      DONE: ;
      default: state_d = LOAD;
    endcase
    proc_go_d  = (state_d == RUN);
    ld_ready_d = (state_d == LOAD);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      ld_addr_q  <= '0;
      dm_out_q   <= '0;
      proc_go_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_addr_q  <= ld_addr_d;
      dm_out_q   <= dm_out_d;
      proc_go_q  <= proc_go_d;
      ld_ready_q <= ld_ready_d;
      done_q     <= done_d;
    end
  end

  assign dm_out   = dm_out_q;
  assign proc_go  = proc_go_q;
  assign ld_ready = ld_ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: load, run access, wrap, end-of-run, dump and reset abort.
module tb_dm_responder;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ar_in = '0;
  logic [16:0] bus_in = '0;
  logic        dm_en = 1'b0, end_process = 1'b0;
  logic [11:0] dm_out;
  logic        proc_go;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [11:0] ld_data = '0;
  logic        ld_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready = 1'b0;
  logic        done;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(DEPTH), .DATA_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(ar_in), .bus_in(bus_in), .dm_en(dm_en),
    .end_process(end_process), .dm_out(dm_out), .proc_go(proc_go),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .done(done)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  int          ld_ptr = 0;
  logic [11:0] model [DEPTH];
  logic [11:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [11:0] e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check(tag, got, {20'h0, e});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ld_valid = 1'b0; dm_en = 1'b0; end_process = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ld_ready", ld_ready, 0);
    check("rst_proc_go", proc_go, 0);
    check("rst_done", done, 0);
    check("rst_dm_out", dm_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_ld_ready_rel", ld_ready, 1);
    ld_ptr = 0;
    sb.delete();
  endtask

  task automatic load_beat(input logic [11:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    model[ld_ptr] = d;
    ld_ptr = (last || ld_ptr == DEPTH - 1) ? 0 : ld_ptr + 1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic run_cycle(input logic [11:0] ar, input logic en, input logic [16:0] bus,
                           input logic endp, input string tag);
    int a;
    ar_in = ar; dm_en = en; bus_in = bus; end_process = endp;
    a = int'(ar) % DEPTH;
    if (en) model[a] = bus[11:0];
    sb.push_back(model[a]);
    step();
    dm_en = 1'b0; end_process = 1'b0;
    sb_check(tag, dm_out);
  endtask

  initial begin
    logic [11:0] d;
    logic [11:0] held;
    logic        stalled;
    logic        pat [4];
    int          beats, budget;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1;
    #2;
    do_reset();

    // Three-beat load; dm_en during LOAD must not touch memory; idle beat must hold.
    dm_en = 1'b1; ar_in = 12'd1; bus_in = 17'h00FFF;
    load_beat(12'h00A, 1'b0);
    dm_en = 1'b0;
    step();
    check("ld_idle_ready", ld_ready, 1);
    check("ld_idle_go", proc_go, 0);
    load_beat(12'h00B, 1'b0);
    load_beat(12'h00C, 1'b1);
    check("ld_ready_drop", ld_ready, 0);
    check("proc_go_run", proc_go, 1);

    run_cycle(12'd1, 1'b0, 17'h0, 1'b0, "rd_addr1");
    run_cycle(12'd0, 1'b0, 17'h0, 1'b0, "rd_addr0");
    run_cycle(12'd2, 1'b0, 17'h0, 1'b0, "rd_addr2");
    run_cycle(12'd5, 1'b1, 17'h1F123, 1'b0, "wr_first");
    run_cycle(12'd5, 1'b0, 17'h0, 1'b0, "rd_after_wr");
    run_cycle(12'h105, 1'b1, 17'h00777, 1'b0, "wr_wrap");
    run_cycle(12'd5, 1'b0, 17'h0, 1'b0, "rd_wrap");

    // Abort RUN with reset, then fill the whole memory without ld_last.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 37 == 5) step();
      d = 12'($urandom_range(0, 4095));
      load_beat(d, 1'b0);
      if (i == DEPTH - 2) check("ld_not_yet_run", proc_go, 0);
    end
    check("ld_full_run", proc_go, 1);
    check("ld_full_ready", ld_ready, 0);

    for (int i = 0; i < 40; i++)
      run_cycle(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), 17'($urandom), 1'b0, "rand_rw");
    for (int i = 0; i < 8; i++)
      run_cycle(12'(i * 3), 1'b0, 17'h0, 1'b0, "rand_rd");
    run_cycle(12'd0, 1'b1, 17'h005A5, 1'b1, "end_wr");
    ar_in = 12'd7;
    step();
    check("dm_out_hold", dm_out, 12'h5A5);
    check("end_go_low", proc_go, 0);

`ifdef DM_DUMP_EN
    check("dump_entry_valid", out_valid, 1);
    for (int i = 0; i < DEPTH; i++) sb.push_back(model[i]);
    beats = 0; budget = 0; stalled = 1'b0; held = '0;
    while (beats < DEPTH && budget < 4 * DEPTH) begin
      out_ready = (budget < 4) ? pat[budget] : 1'($urandom_range(0, 1));
      check("dump_valid", out_valid, 1);
      if (stalled) check("dump_stable", out_data, held);
      if (out_ready) begin
        sb_check("dump_data", out_data);
        beats++;
        stalled = 1'b0;
      end else begin
        held = out_data;
        stalled = 1'b1;
      end
      step();
      budget++;
    end
    if (beats < DEPTH) check("dump_timeout", beats, DEPTH);
    out_ready = 1'b0;
    check("dump_done", done, 1);
    check("dump_valid_off", out_valid, 0);
    check("dump_dm_out_hold", dm_out, 12'h5A5);

    // Second run: abort the dump at word 10 with reset.
    do_reset();
    load_beat(12'h0D1, 1'b1);
    run_cycle(12'd3, 1'b0, 17'h0, 1'b0, "run2_rd3");
    run_cycle(12'd0, 1'b0, 17'h0, 1'b1, "run2_end");
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("dump2_data", out_data, model[i]);
      step();
    end
    out_ready = 1'b0;
    check("dump2_addr10", out_data, model[10]);
    check("dump2_valid10", out_valid, 1);
    do_reset();
`else
    check("nodump_done", done, 1);
    check("nodump_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    step();
    check("nodump_done_hold", done, 1);
    check("nodump_valid_hold", out_valid, 0);
    check("nodump_data", out_data, 0);
    out_ready = 1'b0;
    do_reset();
`endif

    load_beat(12'h0E2, 1'b1);
    check("reload_go", proc_go, 1);
    for (int i = 0; i < 6; i++)
      run_cycle(12'(i), 1'b0, 17'h0, 1'b0, "kept_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
